// File: rtl/cond_pipe_pkg.sv
// cond_pipe_pkg: shared definitions for the conditional pipeline control path.
//   - ARM condition-code encodings (Instr[31:28])
//   - NZCV bit positions inside the 4-bit flags vector
//   - multi-cycle handshake FSM state type
package cond_pipe_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_WAIT = 1'b1
  } mc_state_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-code evaluator.
// Ports:
//   cond  in  4  condition field
//   flags in  4  {N,Z,C,V}
//   pass  out 1  instruction executes under these flags
// The NV encoding (4'hF) never passes.
module cond_eval
  import cond_pipe_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_pipe_ctrl.sv
// cond_pipe_ctrl: Execute-stage control register, condition gating, NZCV flags
// register, multi-cycle unit handshake and NUM_POST post-Execute control stages.
// Ports:
//   CLK, Reset                     clock, synchronous active-high reset
//   dec_*                          decoded instruction fields from the decoder
//   flush_e                        turn the next Execute load into a bubble
//   alu_flags                      {N,Z,C,V} produced by the Execute instruction
//   mc_done                        multi-cycle unit result ready
//   dec_ready                      Execute accepts a new instruction
//   mc_start / mc_hold             multi-cycle start pulse / Execute frozen
//   e_ctrl, pcsrc_e, regwrite_e,
//   memwrite_e                     Execute-stage bundle and gated controls
//   flags_q                        architectural NZCV
//   post_valid/regwrite/memwrite   per post stage, bit k = stage k
//   post_ctrl                      stage k at [k*CTRL_W +: CTRL_W]
module cond_pipe_ctrl
  import cond_pipe_pkg::*;
#(
  parameter int NUM_POST = 2,
  parameter int CTRL_W   = 8
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       dec_valid,
  input  logic [3:0]                 dec_cond,
  input  logic                       dec_pcs,
  input  logic                       dec_regw,
  input  logic                       dec_memw,
  input  logic                       dec_nowrite,
  input  logic                       dec_mstart,
  input  logic [1:0]                 dec_flagw,
  input  logic [CTRL_W-1:0]          dec_ctrl,
  input  logic                       flush_e,
  input  logic [3:0]                 alu_flags,
  input  logic                       mc_done,
  output logic                       dec_ready,
  output logic                       mc_start,
  output logic                       mc_hold,
  output logic [CTRL_W-1:0]          e_ctrl,
  output logic                       pcsrc_e,
  output logic                       regwrite_e,
  output logic                       memwrite_e,
  output logic [3:0]                 flags_q,
  output logic [NUM_POST-1:0]        post_valid,
  output logic [NUM_POST-1:0]        post_regwrite,
  output logic [NUM_POST-1:0]        post_memwrite,
  output logic [NUM_POST*CTRL_W-1:0] post_ctrl
);

  logic              vld_p0;
  logic [3:0]        cond_p0;
  logic              pcs_p0;
  logic              regw_p0;
  logic              memw_p0;
  logic              nowrite_p0;
  logic              mstart_p0;
  logic [1:0]        flagw_p0;
  logic [CTRL_W-1:0] ctrl_p0;
  logic              pass_p0;

  mc_state_t state, state_nxt;

  // ---- Decode -> Execute boundary ----
  always_ff @(posedge CLK) begin
    if (Reset) begin
      vld_p0     <= 1'b0;
      cond_p0    <= 4'h0;
      pcs_p0     <= 1'b0;
      regw_p0    <= 1'b0;
      memw_p0    <= 1'b0;
      nowrite_p0 <= 1'b0;
      mstart_p0  <= 1'b0;
      flagw_p0   <= 2'b00;
      ctrl_p0    <= '0;
    end else if (!mc_hold) begin
      if (flush_e || !dec_valid) begin
        vld_p0     <= 1'b0;
        cond_p0    <= 4'h0;
        pcs_p0     <= 1'b0;
        regw_p0    <= 1'b0;
        memw_p0    <= 1'b0;
        nowrite_p0 <= 1'b0;
        mstart_p0  <= 1'b0;
        flagw_p0   <= 2'b00;
        ctrl_p0    <= '0;
      end else begin
        vld_p0     <= 1'b1;
        cond_p0    <= dec_cond;
        pcs_p0     <= dec_pcs;
        regw_p0    <= dec_regw;
        memw_p0    <= dec_memw;
        nowrite_p0 <= dec_nowrite;
        mstart_p0  <= dec_mstart;
        flagw_p0   <= dec_flagw;
        ctrl_p0    <= dec_ctrl;
      end
    end
  end

  cond_eval u_cond_eval (
    .cond  (cond_p0),
    .flags (flags_q),
    .pass  (pass_p0)
  );

  assign e_ctrl     = ctrl_p0;
  assign pcsrc_e    = vld_p0 & pcs_p0 & pass_p0;
  assign regwrite_e = vld_p0 & regw_p0 & pass_p0 & !nowrite_p0;
  assign memwrite_e = vld_p0 & memw_p0 & pass_p0;
  assign dec_ready  = !mc_hold;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= MC_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The start cycle already holds Execute; in WAIT the hold drops in the very
  // cycle mc_done arrives so the instruction leaves on that edge.
  always_comb begin
    state_nxt = state;
    mc_start  = 1'b0;
    mc_hold   = 1'b0;
    case (state)
      MC_IDLE: begin
        if (vld_p0 && mstart_p0 && pass_p0) begin
          mc_start  = 1'b1;
          mc_hold   = 1'b1;
          state_nxt = MC_WAIT;
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_nxt = MC_IDLE;
        end else begin
          mc_hold = 1'b1;
        end
      end
      default: state_nxt = MC_IDLE;
    endcase
  end

  // Flags commit on the exit edge of a valid, passing instruction, so a
  // directly following conditional instruction already sees them.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      flags_q <= 4'h0;
    end else if (vld_p0 && pass_p0 && !mc_hold) begin
      if (flagw_p0[1]) begin
        flags_q[FLAG_N] <= alu_flags[FLAG_N];
        flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (flagw_p0[0]) begin
        flags_q[FLAG_C] <= alu_flags[FLAG_C];
        flags_q[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

  logic              s0_vld, s0_rw, s0_mw;
  logic              vld_pn  [NUM_POST];
  logic              rw_pn   [NUM_POST];
  logic              mw_pn   [NUM_POST];
  logic [CTRL_W-1:0] ctrl_pn [NUM_POST];

  // A held instruction has not left Execute yet, so stage 0 sees a bubble.
  assign s0_vld = vld_p0 & !mc_hold;
  assign s0_rw  = regwrite_e & !mc_hold;
  assign s0_mw  = memwrite_e & !mc_hold;

  // ---- Execute -> post stage k boundary ----
  for (genvar k = 0; k < NUM_POST; k++) begin : g_post
    if (k == 0) begin : g_first
      always_ff @(posedge CLK) begin
        if (Reset) begin
          vld_pn[k]  <= 1'b0;
          rw_pn[k]   <= 1'b0;
          mw_pn[k]   <= 1'b0;
          ctrl_pn[k] <= '0;
        end else begin
          vld_pn[k]  <= s0_vld;
          rw_pn[k]   <= s0_rw;
          mw_pn[k]   <= s0_mw;
          ctrl_pn[k] <= ctrl_p0;
        end
      end
    end else begin : g_rest
      always_ff @(posedge CLK) begin
        if (Reset) begin
          vld_pn[k]  <= 1'b0;
          rw_pn[k]   <= 1'b0;
          mw_pn[k]   <= 1'b0;
          ctrl_pn[k] <= '0;
        end else begin
          vld_pn[k]  <= vld_pn[k-1];
          rw_pn[k]   <= rw_pn[k-1];
          mw_pn[k]   <= mw_pn[k-1];
          ctrl_pn[k] <= ctrl_pn[k-1];
        end
      end
    end

    assign post_valid[k]                    = vld_pn[k];
    assign post_regwrite[k]                 = rw_pn[k];
    assign post_memwrite[k]                 = mw_pn[k];
    assign post_ctrl[k*CTRL_W +: CTRL_W]    = ctrl_pn[k];
  end

endmodule
